// File: rtl/mouse_packet_assembler_pkg.sv
// rtl/mouse_packet_assembler_pkg.sv - shared state encoding, PS/2 codes and byte0 field layout
package mouse_packet_assembler_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  // Controller responses that can appear in the stream but are never packet headers
  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam logic [7:0] PS2_BAT = 8'hAA;

  // Bit positions inside byte0 of a standard 3-byte PS/2 mouse packet
  localparam int B0_LEFT   = 0;
  localparam int B0_RIGHT  = 1;
  localparam int B0_MIDDLE = 2;
  localparam int B0_SYNC   = 3;
  localparam int B0_X_SIGN = 4;
  localparam int B0_Y_SIGN = 5;
  localparam int B0_X_OVF  = 6;
  localparam int B0_Y_OVF  = 7;

  // byte0 minus the always-one sync bit, which carries no information once accepted
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic middle;
    logic right;
    logic left;
  } header_t;

  function automatic header_t decode_header(input logic [7:0] b);
    header_t h;
    h.left   = b[B0_LEFT];
    h.right  = b[B0_RIGHT];
    h.middle = b[B0_MIDDLE];
    h.x_sign = b[B0_X_SIGN];
    h.y_sign = b[B0_Y_SIGN];
    h.x_ovf  = b[B0_X_OVF];
    h.y_ovf  = b[B0_Y_OVF];
    return h;
  endfunction

  function automatic logic is_ack_or_bat(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT);
  endfunction

endpackage

// File: rtl/mouse_packet_assembler_byte_gap_timer.sv
// rtl/mouse_packet_assembler_byte_gap_timer.sv - inter-byte gap counter that flags a stalled packet
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count idle cycles while a packet is in progress; stop at the terminal value
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mouse_packet_assembler.sv
// rtl/mouse_packet_assembler.sv - assembles 3-byte PS/2 mouse packets into button and delta outputs
module mouse_packet_assembler
  import mouse_packet_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic [7:0]           ps2_received_data,
  input  logic                 ps2_received_data_en,
  output logic                 left_button,
  output logic                 right_button,
  output logic                 middle_button,
  output logic [8:0]           mouse_delta_x,
  output logic [8:0]           mouse_delta_y,
  output logic                 x_overflow,
  output logic                 y_overflow,
  output logic                 mouse_data_valid,
  output logic [ERR_CNT_W-1:0] sync_error_count
);

  state_t     state;
  header_t    byte0_q;
  logic [7:0] byte1_q;
  logic       gap_enable;
  logic       gap_clear;
  logic       gap_expired;

  // Gap timing only matters once a header has been accepted
  assign gap_enable = (state == WAIT_B1) || (state == WAIT_B2);
  assign gap_clear  = ps2_received_data_en || gap_expired;

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .clear    (gap_clear),
    .enable   (gap_enable),
    .expired  (gap_expired)
  );

  // Packet FSM; a strobe always takes priority over a coincident timeout
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state            <= WAIT_B0;
      byte0_q          <= '0;
      byte1_q          <= '0;
      left_button      <= 1'b0;
      right_button     <= 1'b0;
      middle_button    <= 1'b0;
      mouse_delta_x    <= '0;
      mouse_delta_y    <= '0;
      x_overflow       <= 1'b0;
      y_overflow       <= 1'b0;
      mouse_data_valid <= 1'b0;
      sync_error_count <= '0;
    end else begin
      mouse_data_valid <= 1'b0;
      if (ps2_received_data_en) begin
        case (state)
          WAIT_B0: begin
            if (is_ack_or_bat(ps2_received_data)) begin
              state <= WAIT_B0;
            end else if (ps2_received_data[B0_SYNC]) begin
              byte0_q <= decode_header(ps2_received_data);
              state   <= WAIT_B1;
            end else if (sync_error_count != '1) begin
              sync_error_count <= sync_error_count + ERR_CNT_W'(1);
            end
          end
          WAIT_B1: begin
            byte1_q <= ps2_received_data;
            state   <= WAIT_B2;
          end
          WAIT_B2: begin
            left_button      <= byte0_q.left;
            right_button     <= byte0_q.right;
            middle_button    <= byte0_q.middle;
            mouse_delta_x    <= {byte0_q.x_sign, byte1_q};
            mouse_delta_y    <= {byte0_q.y_sign, ps2_received_data};
            x_overflow       <= byte0_q.x_ovf;
            y_overflow       <= byte0_q.y_ovf;
            mouse_data_valid <= 1'b1;
            state            <= WAIT_B0;
          end
          default: begin
            state <= WAIT_B0;
          end
        endcase
      end else if (gap_expired) begin
        state <= WAIT_B0;
        if (sync_error_count != '1) begin
          sync_error_count <= sync_error_count + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_assembler.sv
// tb/tb_mouse_packet_assembler.sv - directed table-driven bench for mouse_packet_assembler
module tb_mouse_packet_assembler;

  localparam int T = 16;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_en;
  logic       left_button, right_button, middle_button;
  logic [8:0] mouse_delta_x, mouse_delta_y;
  logic       x_overflow, y_overflow, mouse_data_valid;
  logic [7:0] sync_error_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic       l, r, m;
    logic [8:0] dx, dy;
    logic       xo, yo;
  } vec_t;

  vec_t vecs[6];

  mouse_packet_assembler #(
    .TIMEOUT_CYCLES(T),
    .ERR_CNT_W(8)
  ) dut (
    .CLOCK_50             (CLOCK_50),
    .reset_n              (reset_n),
    .ps2_received_data    (ps2_received_data),
    .ps2_received_data_en (ps2_received_data_en),
    .left_button          (left_button),
    .right_button         (right_button),
    .middle_button        (middle_button),
    .mouse_delta_x        (mouse_delta_x),
    .mouse_delta_y        (mouse_delta_y),
    .x_overflow           (x_overflow),
    .y_overflow           (y_overflow),
    .mouse_data_valid     (mouse_data_valid),
    .sync_error_count     (sync_error_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) if (mouse_data_valid === 1'b1) pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge CLOCK_50);
    ps2_received_data    = b;
    ps2_received_data_en = 1'b1;
    @(negedge CLOCK_50);
    ps2_received_data_en = 1'b0;
  endtask

  // Three consecutive strobes; returns on the cycle the valid pulse should be visible
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge CLOCK_50);
    ps2_received_data_en = 1'b1;
    ps2_received_data    = b0;
    @(negedge CLOCK_50);
    ps2_received_data    = b1;
    @(negedge CLOCK_50);
    ps2_received_data    = b2;
    @(negedge CLOCK_50);
    ps2_received_data_en = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_btn"}, {29'd0, left_button, right_button, middle_button}, 32'd0);
    chk({tag, "_dx"}, {23'd0, mouse_delta_x}, 32'd0);
    chk({tag, "_dy"}, {23'd0, mouse_delta_y}, 32'd0);
    chk({tag, "_ovf_valid"}, {29'd0, x_overflow, y_overflow, mouse_data_valid}, 32'd0);
    chk({tag, "_err"}, {24'd0, sync_error_count}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_zero_outputs("in_reset");
    reset_n = 1'b1;
    exp_pulses = pulses;
  endtask

  initial begin
    vecs[0] = '{8'h09, 8'h05, 8'hFB, 1, 0, 0, 9'h005, 9'h0FB, 0, 0};
    vecs[1] = '{8'hC8, 8'h80, 8'h7F, 0, 0, 0, 9'h080, 9'h07F, 1, 1};
    vecs[2] = '{8'h3A, 8'hF0, 8'h10, 0, 1, 0, 9'h1F0, 9'h110, 0, 0};
    vecs[3] = '{8'h0C, 8'h00, 8'h00, 0, 0, 1, 9'h000, 9'h000, 0, 0};
    vecs[4] = '{8'h0F, 8'hFF, 8'hFF, 1, 1, 1, 9'h0FF, 9'h0FF, 0, 0};
    vecs[5] = '{8'h38, 8'h01, 8'h02, 0, 0, 0, 9'h101, 9'h102, 0, 0};

    reset_n = 1'b0;
    ps2_received_data = 8'h00;
    ps2_received_data_en = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check_zero_outputs("reset");
    reset_n = 1'b1;

    // Table of complete back-to-back packets
    for (int i = 0; i < 6; i++) begin
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      chk($sformatf("v%0d_valid", i), {31'd0, mouse_data_valid}, 32'd1);
      chk($sformatf("v%0d_left", i), {31'd0, left_button}, {31'd0, vecs[i].l});
      chk($sformatf("v%0d_right", i), {31'd0, right_button}, {31'd0, vecs[i].r});
      chk($sformatf("v%0d_middle", i), {31'd0, middle_button}, {31'd0, vecs[i].m});
      chk($sformatf("v%0d_dx", i), {23'd0, mouse_delta_x}, {23'd0, vecs[i].dx});
      chk($sformatf("v%0d_dy", i), {23'd0, mouse_delta_y}, {23'd0, vecs[i].dy});
      chk($sformatf("v%0d_xovf", i), {31'd0, x_overflow}, {31'd0, vecs[i].xo});
      chk($sformatf("v%0d_yovf", i), {31'd0, y_overflow}, {31'd0, vecs[i].yo});
      chk($sformatf("v%0d_err", i), {24'd0, sync_error_count}, 32'd0);
      @(negedge CLOCK_50);
      chk($sformatf("v%0d_valid_drop", i), {31'd0, mouse_data_valid}, 32'd0);
      chk($sformatf("v%0d_pulses", i), pulses, i + 1);
    end

    // Partial packet holds outputs, then reset mid-packet discards it
    strobe(8'h08);
    strobe(8'h02);
    chk("partial_hold_dx", {23'd0, mouse_delta_x}, 32'h101);
    chk("partial_hold_dy", {23'd0, mouse_delta_y}, 32'h102);
    exp_pulses = pulses;
    do_reset();
    strobe(8'h04);
    @(negedge CLOCK_50);
    chk("rst_mid_err", {24'd0, sync_error_count}, 32'd1);
    chk("rst_mid_no_pulse", pulses, exp_pulses);
    send_pkt(8'h09, 8'h05, 8'hFB);
    chk("rst_resume_valid", {31'd0, mouse_data_valid}, 32'd1);
    chk("rst_resume_left", {31'd0, left_button}, 32'd1);

    // ACK/BAT ignored silently, sync-less byte counted
    do_reset();
    strobe(8'hFA);
    strobe(8'hAA);
    strobe(8'h00);
    send_pkt(8'h3A, 8'hF0, 8'h10);
    chk("ackbat_valid", {31'd0, mouse_data_valid}, 32'd1);
    chk("ackbat_right", {29'd0, left_button, right_button, middle_button}, 32'b010);
    chk("ackbat_dx", {23'd0, mouse_delta_x}, 32'h1F0);
    chk("ackbat_dy", {23'd0, mouse_delta_y}, 32'h110);
    chk("ackbat_err", {24'd0, sync_error_count}, 32'd1);
    @(negedge CLOCK_50);
    chk("ackbat_pulses", pulses, exp_pulses + 1);

    // Timeout: one cycle short is still fine, the next cycle drops the packet
    do_reset();
    send_pkt(8'h09, 8'h05, 8'hFB);
    @(negedge CLOCK_50);
    exp_pulses = pulses;
    strobe(8'h08);
    strobe(8'h01);
    repeat (T - 1) @(negedge CLOCK_50);
    chk("tmo_before_err", {24'd0, sync_error_count}, 32'd0);
    @(negedge CLOCK_50);
    chk("tmo_after_err", {24'd0, sync_error_count}, 32'd1);
    chk("tmo_hold_left", {31'd0, left_button}, 32'd1);
    chk("tmo_hold_dx", {23'd0, mouse_delta_x}, 32'h005);
    chk("tmo_no_pulse", pulses, exp_pulses);
    send_pkt(8'h0C, 8'h00, 8'h00);
    chk("tmo_next_valid", {31'd0, mouse_data_valid}, 32'd1);
    chk("tmo_next_btn", {29'd0, left_button, right_button, middle_button}, 32'b001);
    chk("tmo_next_err", {24'd0, sync_error_count}, 32'd1);

    // Strobe arriving in the timeout cycle wins
    do_reset();
    strobe(8'h08);
    repeat (T - 2) @(negedge CLOCK_50);
    strobe(8'h01);
    strobe(8'h02);
    chk("tie_valid", {31'd0, mouse_data_valid}, 32'd1);
    chk("tie_dx", {23'd0, mouse_delta_x}, 32'h001);
    chk("tie_dy", {23'd0, mouse_delta_y}, 32'h002);
    chk("tie_err", {24'd0, sync_error_count}, 32'd0);

    // Error counter saturation with 300 back-to-back bad bytes
    do_reset();
    @(negedge CLOCK_50);
    ps2_received_data = 8'h00;
    ps2_received_data_en = 1'b1;
    repeat (300) @(negedge CLOCK_50);
    ps2_received_data_en = 1'b0;
    @(negedge CLOCK_50);
    chk("sat_err", {24'd0, sync_error_count}, 32'd255);
    chk("sat_no_pulse", pulses, exp_pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_packet_assembler.md
MOUSE_PACKET_ASSEMBLER -- requirements
Module: mouse_packet_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum inter-byte gap in CLOCK_50 cycles (20 ms) within one packet.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, giving the width of the sync-error counter.
REQ-003 SHALL use one clock and an asynchronous active-low reset, as decided.
REQ-004 CLOCK_50  input  1  system clock; the only clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ps2_received_data  input  8  byte from the PS/2 controller.
REQ-007 ps2_received_data_en  input  1  one-cycle strobe; ps2_received_data is valid when this is high.
REQ-008 left_button  output  1  byte0 bit0 of the last complete packet.
REQ-009 right_button  output  1  byte0 bit1 of the last complete packet.
REQ-010 middle_button  output  1  byte0 bit2 of the last complete packet.
REQ-011 mouse_delta_x  output  9  {byte0 bit4, byte1}; bit8 = negative direction.
REQ-012 mouse_delta_y  output  9  {byte0 bit5, byte2}; bit8 = negative direction (PS/2 up).
REQ-013 x_overflow  output  1  byte0 bit6 of the last packet.
REQ-014 y_overflow  output  1  byte0 bit7 of the last packet.
REQ-015 mouse_data_valid  output  1  one-cycle pulse marking a new complete packet.
REQ-016 sync_error_count  output  ERR_CNT_W  saturating count of discarded bytes and timeouts.

Function
REQ-017 SHALL implement the states WAIT_B0, WAIT_B1 and WAIT_B2; bytes are consumed only in cycles where ps2_received_data_en=1.
REQ-018 In WAIT_B0, a byte with bit3=1 that is not 0xFA (ACK) or 0xAA (BAT) SHALL be latched as byte0, with a transition to WAIT_B1.
REQ-019 In WAIT_B0, a byte with bit3=0 SHALL be discarded and sync_error_count incremented; 0xFA and 0xAA SHALL be discarded silently.
REQ-020 In WAIT_B1, any byte SHALL be latched as byte1, with a transition to WAIT_B2.
REQ-021 In WAIT_B2, any byte SHALL complete the packet and return the state to WAIT_B0.
REQ-022 On the cycle after byte2 is strobed, all packet outputs SHALL update together and mouse_data_valid SHALL be high for exactly that one cycle (latency 1).
REQ-023 Packet outputs SHALL hold their values until the next complete packet; a partial packet SHALL never alter them.
REQ-024 A gap counter SHALL clear on every strobe and count only in WAIT_B1 and WAIT_B2.
REQ-025 When the gap counter reaches TIMEOUT_CYCLES-1 without a strobe, the state SHALL return to WAIT_B0, the partial packet SHALL be dropped and sync_error_count incremented.
REQ-026 When a strobe and the timeout occur in the same cycle, the strobe SHALL win: the byte is processed normally and no error is counted.
REQ-027 sync_error_count SHALL saturate at all-ones and not wrap.
REQ-028 Deltas SHALL pass through unmodified when an overflow bit is set; only the flag reports the overflow.
REQ-029 Back-to-back strobes on consecutive cycles SHALL each be consumed without loss.

Reset
REQ-030 While reset_n=0, the state SHALL be WAIT_B0, and all outputs, the byte latches and the gap counter SHALL be 0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet with no mouse_data_valid pulse, and reception SHALL resume at WAIT_B0 on the first edge after release.

Structure
REQ-032 The shared package SHALL hold the state encoding, PS2_ACK=8'hFA, PS2_BAT=8'hAA and the byte0 bit-position constants.
REQ-033 The gap counter SHALL be a sub-module, byte_gap_timer, with inputs clear and enable and output expired.

Verification
REQ-034 Strobe 0x09, 0x05, 0xFB -> one valid pulse a cycle later with left=1, delta_x=9'h005, delta_y=9'h0FB, error count 0.
REQ-035 Strobe 0xFA, 0xAA, 0x00 then 0x3A, 0xF0, 0x10 -> a single pulse with right=1, delta_x=9'h1F0, delta_y=9'h110, error count 1 (the 0x00 byte).
REQ-036 Strobe 0x08, 0x01, then no strobe for TIMEOUT_CYCLES, then 0x0C, 0x00, 0x00 -> no pulse for the first bytes, error count 1, then a pulse with middle=1.
REQ-037 Strobe 0x08, 0x02, then pulse reset_n low for 3 cycles, then 0x04 -> no pulse, state WAIT_B0, error count 1 (0x04 has bit3=0).
REQ-038 Strobe 300 bytes of 0x00 -> error count saturates at 255 with no pulse.
REQ-039 Strobe 0xC8, 0x80, 0x7F on consecutive cycles -> one pulse with x_overflow=1, y_overflow=1, delta_x=9'h080, delta_y=9'h07F.
